// File: rtl/traffic_phase_sequencer.sv
// Demand-driven two-road intersection sequencer with min/max green, yellow and all-red clearance.
// Optional pedestrian walk phase is built only when PED_WALK_EN is defined.
module traffic_phase_sequencer #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_2,
  input  logic       ped_req,
  output logic [2:0] light_1,
  output logic [2:0] light_2,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    AR_1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    AR_2   = 3'd5,
    WALK   = 3'd6
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [7:0] MIN_LAST    = 8'(GREEN_MIN - 1);
  localparam logic [7:0] MAX_LAST    = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_T - 1);

  if (GREEN_MIN < 1 || GREEN_MIN > 255 || GREEN_MAX < 1 || GREEN_MAX > 255 ||
      YELLOW_T < 1 || YELLOW_T > 255 || ALLRED_T < 1 || ALLRED_T > 255 ||
      WALK_T < 1 || WALK_T > 255 || GREEN_MAX < GREEN_MIN) begin : g_param_check
    $error("traffic_phase_sequencer: interval parameters out of range");
  end

  state_t     state_q;
  state_t     state_d;
  logic [7:0] timer;
  logic       side_req;
  logic       ped_pend;
  logic       entering;

  assign entering = (state_d != state_q);

  // NOTE: every write to state in a clocked block is non-blocking so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= AR_2;
      timer    <= '0;
      side_req <= 1'b0;
    end else begin
      state_q <= state_d;
      // Saturate so an indefinitely held MAIN_G never wraps back below the minimum.
      if (entering)
        timer <= '0;
      else if (timer != 8'hFF)
        timer <= timer + 8'd1;
      if (entering && state_d == SIDE_G)
        side_req <= 1'b0;
      else if (sensor_2 && state_q != SIDE_G && state_q != SIDE_Y)
        side_req <= 1'b1;
    end
  end

`ifdef PED_WALK_EN
  // Clear on WALK entry takes priority over a same-cycle button press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ped_pend <= 1'b0;
    else if (entering && state_d == WALK)
      ped_pend <= 1'b0;
    else if (ped_req && state_q != WALK)
      ped_pend <= 1'b1;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend       = 1'b0;
`endif

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_G: if (timer >= MIN_LAST && (side_req || ped_pend)) state_d = MAIN_Y;
      MAIN_Y: if (timer == YELLOW_LAST) state_d = AR_1;
      AR_1:   if (timer == ALLRED_LAST) state_d = ped_pend ? WALK : SIDE_G;
      WALK:   if (timer == WALK_LAST) state_d = side_req ? SIDE_G : AR_2;
      SIDE_G: if ((timer >= MIN_LAST && !sensor_2) || timer == MAX_LAST) state_d = SIDE_Y;
      SIDE_Y: if (timer == YELLOW_LAST) state_d = AR_2;
      AR_2:   if (timer == ALLRED_LAST) state_d = MAIN_G;
      default: state_d = AR_2;
    endcase
  end

  // Moore decode: both heads default to red so no state can show two greens.
  always_comb begin
    light_1 = RED;
    light_2 = RED;
    walk    = 1'b0;
    case (state_q)
      MAIN_G: light_1 = GREEN;
      MAIN_Y: light_1 = YELLOW;
      SIDE_G: light_2 = GREEN;
      SIDE_Y: light_2 = YELLOW;
`ifdef PED_WALK_EN
      WALK:   walk = 1'b1;
`endif
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer: vector table, hand-written corner sequences
// and randomized demand checked cycle-by-cycle against an interval-based reference model.
module tb_traffic_phase_sequencer;

  localparam int GREEN_MIN = 8;
  localparam int GREEN_MAX = 20;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 2;
  localparam int WALK_T    = 6;
`ifdef PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       sensor_2 = 1'b0;
  logic       ped_req  = 1'b0;
  logic [2:0] light_1;
  logic [2:0] light_2;
  logic [2:0] phase;
  logic       walk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, cycles already spent in it, pending requests.
  int m_phase;
  int m_dwell;
  bit m_side;
  bit m_ped;

  typedef struct {
    int         n;
    bit         s;
    bit         p;
    logic [2:0] ph;
  } vec_t;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(
    .GREEN_MIN(GREEN_MIN),
    .GREEN_MAX(GREEN_MAX),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .WALK_T   (WALK_T)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sensor_2(sensor_2),
    .ped_req (ped_req),
    .light_1 (light_1),
    .light_2 (light_2),
    .walk    (walk),
    .phase   (phase)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int fixed_len(input int p);
    case (p)
      1, 4:    return YELLOW_T;
      2, 5:    return ALLRED_T;
      6:       return WALK_T;
      default: return 0;
    endcase
  endfunction

  // Expected {phase, light_1, light_2, walk} for a model phase.
  function automatic logic [9:0] expect_out(input int p);
    logic [2:0] l1;
    logic [2:0] l2;
    l1 = (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    l2 = (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
    return {3'(p), l1, l2, (p == 6)};
  endfunction

  task automatic model_reset();
    m_phase = 5;
    m_dwell = 0;
    m_side  = 1'b0;
    m_ped   = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_advance();
    int nxt;
    int done;
    nxt  = m_phase;
    done = m_dwell + 1;
    case (m_phase)
      0: if (done >= GREEN_MIN && (m_side || m_ped)) nxt = 1;
      3: if ((done >= GREEN_MIN && !sensor_2) || done == GREEN_MAX) nxt = 4;
      default:
        if (done == fixed_len(m_phase)) begin
          case (m_phase)
            1:       nxt = 2;
            2:       nxt = m_ped ? 6 : 3;
            4:       nxt = 5;
            5:       nxt = 0;
            default: nxt = m_side ? 3 : 5;
          endcase
        end
    endcase
    if (nxt == 3 && m_phase != 3) m_side = 1'b0;
    else if (sensor_2 && m_phase != 3 && m_phase != 4) m_side = 1'b1;
    if (PED_EN) begin
      if (nxt == 6 && m_phase != 6) m_ped = 1'b0;
      else if (ped_req && m_phase != 6) m_ped = 1'b1;
    end
    m_dwell = (nxt != m_phase) ? 0 : done;
    m_phase = nxt;
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    check("model_outputs", 32'({phase, light_1, light_2, walk}), 32'(expect_out(m_phase)));
    check("safety_one_red", 32'(light_1 == 3'b100 || light_2 == 3'b100), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("reset_async", 32'({phase, light_1, light_2, walk}), 32'({3'd5, 3'b100, 3'b100, 1'b0}));
    @(posedge clk);
    #1;
    check("reset_held", 32'({phase, light_1, light_2, walk}), 32'({3'd5, 3'b100, 3'b100, 1'b0}));
    reset = 1'b1;
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget);
    int n;
    n = 0;
    while (phase != p && n < budget) begin
      step();
      n++;
    end
    check("wait_phase", 32'(phase), 32'(p));
  endtask

  task automatic run_length(input logic [2:0] p, output int n);
    n = 0;
    while (phase == p && n < 300) begin
      step();
      n++;
    end
  endtask

  vec_t tbl [25];
  int   len;

  initial begin
    tbl = '{
      '{2, 1'b0, 1'b0, 3'd0}, '{2, 1'b0, 1'b0, 3'd0}, '{1, 1'b1, 1'b0, 3'd0}, '{4, 1'b0, 1'b0, 3'd0},
      '{1, 1'b0, 1'b0, 3'd1}, '{2, 1'b0, 1'b0, 3'd1}, '{1, 1'b0, 1'b0, 3'd2}, '{1, 1'b0, 1'b0, 3'd2},
      '{1, 1'b0, 1'b0, 3'd3}, '{7, 1'b0, 1'b0, 3'd3}, '{1, 1'b0, 1'b0, 3'd4}, '{2, 1'b0, 1'b0, 3'd4},
      '{1, 1'b0, 1'b0, 3'd5}, '{1, 1'b0, 1'b0, 3'd5}, '{1, 1'b0, 1'b0, 3'd0}, '{30, 1'b0, 1'b0, 3'd0},
      '{1, 1'b1, 1'b0, 3'd0}, '{1, 1'b0, 1'b0, 3'd1}, '{3, 1'b0, 1'b0, 3'd2}, '{2, 1'b0, 1'b0, 3'd3},
      '{10, 1'b1, 1'b0, 3'd3}, '{1, 1'b0, 1'b0, 3'd4}, '{3, 1'b0, 1'b0, 3'd5}, '{2, 1'b0, 1'b0, 3'd0},
      '{20, 1'b0, 1'b0, 3'd0}
    };

    #2;
    do_reset();

    // Reset release with no demand: AR_2 for two cycles, then MAIN_G held.
    check("post_reset_phase", 32'(phase), 32'd5);
    step();
    check("ar2_second_cycle", 32'(phase), 32'd5);
    for (int i = 0; i < 100; i++) step();
    check("idle_main_g", 32'({phase, light_1, light_2}), 32'({3'd0, 3'b001, 3'b100}));

    // Vector table from a fresh reset.
    do_reset();
    foreach (tbl[i]) begin
      sensor_2 = tbl[i].s;
      ped_req  = tbl[i].p;
      for (int k = 0; k < tbl[i].n; k++) step();
      check($sformatf("vector_%0d", i), 32'(phase), 32'(tbl[i].ph));
    end
    sensor_2 = 1'b0;
    ped_req  = 1'b0;

    // Side road held: green capped at GREEN_MAX, then MAIN_G exactly GREEN_MIN.
    sensor_2 = 1'b1;
    wait_phase(3'd3, 100);
    run_length(3'd3, len);
    check("side_g_max_len", 32'(len), 32'(GREEN_MAX));
    check("after_side_g", 32'(phase), 32'd4);
    wait_phase(3'd0, 100);
    run_length(3'd0, len);
    check("main_g_min_len", 32'(len), 32'(GREEN_MIN));
    check("after_main_g", 32'(phase), 32'd1);
    sensor_2 = 1'b0;
    wait_phase(3'd0, 100);
    for (int i = 0; i < 20; i++) step();

`ifdef PED_WALK_EN
    // Pedestrian alone: WALK for WALK_T cycles, then AR_2 and back to MAIN_G.
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase(3'd6, 50);
    check("walk_lamp", 32'({walk, light_1, light_2}), 32'({1'b1, 3'b100, 3'b100}));
    run_length(3'd6, len);
    check("walk_len", 32'(len), 32'(WALK_T));
    check("walk_to_ar2", 32'(phase), 32'd5);
    wait_phase(3'd0, 10);
    for (int i = 0; i < 20; i++) step();

    // Pedestrian with a vehicle: WALK hands over to SIDE_G.
    ped_req  = 1'b1;
    sensor_2 = 1'b1;
    step();
    ped_req  = 1'b0;
    sensor_2 = 1'b0;
    wait_phase(3'd6, 50);
    run_length(3'd6, len);
    check("walk_len_with_side", 32'(len), 32'(WALK_T));
    check("walk_to_side_g", 32'(phase), 32'd3);
    wait_phase(3'd0, 100);
    for (int i = 0; i < 20; i++) step();
`else
    // Without the walk feature the button has no effect.
    for (int i = 0; i < 50; i++) begin
      ped_req = (i % 5 == 0);
      step();
    end
    ped_req = 1'b0;
    check("ped_ignored", 32'({phase, walk}), 32'({3'd0, 1'b0}));
`endif

    // Reset in SIDE_G cycle 4, between clock edges.
    sensor_2 = 1'b1;
    step();
    sensor_2 = 1'b0;
    wait_phase(3'd3, 50);
    for (int i = 0; i < 3; i++) step();
    check("side_g_before_reset", 32'(phase), 32'd3);
    do_reset();
    for (int i = 0; i < 60; i++) step();
    check("main_g_after_reset", 32'(phase), 32'd0);

    // A pending side request is discarded by reset.
    sensor_2 = 1'b1;
    step();
    sensor_2 = 1'b0;
    step();
    do_reset();
    for (int i = 0; i < 60; i++) step();
    check("request_dropped_by_reset", 32'(phase), 32'd0);

    // Randomized demand against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) sensor_2 = ~sensor_2;
      ped_req = ($urandom_range(0, 40) == 0);
      step();
    end
    sensor_2 = 1'b0;
    ped_req  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Two-road intersection controller that sequences the main-road (`light_1`) and side-road (`light_2`) signal heads. It latches side-road vehicle and pedestrian requests and applies minimum and maximum green times, yellow and all-red clearance intervals, and an optional pedestrian walk phase. It extends the fixed-cycle `traffic_lights` block into a demand-driven scheduler, with the same light encoding and port style.

## Interface
- `GREEN_MIN`, 8: minimum green, in cycles, for either road.
- `GREEN_MAX`, 20: maximum side-road green, in cycles.
- `YELLOW_T`, 3: yellow interval, in cycles.
- `ALLRED_T`, 2: all-red clearance interval, in cycles.
- `WALK_T`, 6: pedestrian walk interval, in cycles. Used only with `PED_WALK_EN`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `sensor_2` input 1: side-road vehicle present (level).
- `ped_req` input 1: pedestrian button (pulse or level).
- `light_1` output 3: main-road head, encoded {red, yellow, green}.
- `light_2` output 3: side-road head, same encoding.
- `walk` output 1: pedestrian walk lamp.
- `phase` output 3: current state code.

## Operation
- States and codes:
  - 0 MAIN_G: light_1=001, light_2=100.
  - 1 MAIN_Y: light_1=010, light_2=100.
  - 2 AR_1: 100/100.
  - 3 SIDE_G: light_1=100, light_2=001.
  - 4 SIDE_Y: light_1=100, light_2=010.
  - 5 AR_2: 100/100.
  - 6 WALK: 100/100, walk=1.
- `walk`=1 only in WALK. Outputs are a Moore decode of the state register.
- Dwell counter: 8-bit `timer`, cleared on every state entry. A state with interval T exits on the edge where `timer`==T-1, giving exactly T cycles of dwell.
- `side_req` latch:
  - Set when `sensor_2`=1 in any state except SIDE_G and SIDE_Y.
  - Cleared on entry to SIDE_G.
- `ped_pend` latch:
  - Set when `ped_req`=1 in any state except WALK.
  - Cleared on entry to WALK.
  - Set and clear in the same cycle: clear wins.
- Transitions:
  - MAIN_G → MAIN_Y when `timer`≥GREEN_MIN-1 and (`side_req` or `ped_pend`). With no request, MAIN_G is held indefinitely.
  - MAIN_Y → AR_1 after YELLOW_T cycles.
  - AR_1 → WALK if `ped_pend`, else SIDE_G, after ALLRED_T cycles.
  - WALK → SIDE_G if `side_req`, else AR_2, after WALK_T cycles.
  - SIDE_G → SIDE_Y when (`timer`≥GREEN_MIN-1 and `sensor_2`=0) or `timer`==GREEN_MAX-1.
  - SIDE_Y → AR_2 after YELLOW_T cycles.
  - AR_2 → MAIN_G after ALLRED_T cycles.
- Parameter constraints:
  - All intervals in the range 1..255.
  - GREEN_MAX ≥ GREEN_MIN.
  - Violations are flagged with an elaboration-time `$error`.
- Safety invariant: `light_1` and `light_2` are never both non-red.

## Timing
- Reset asserted (`reset`=0), asynchronously and in any state: state=AR_2, `timer`=0, `side_req`=0, `ped_pend`=0, light_1=100, light_2=100, walk=0, phase=5.
- First edge after release starts AR_2 dwell; MAIN_G begins ALLRED_T cycles later.
- Request latency: a request sampled at edge N is visible to the transition logic at edge N+1.
- State changes and output changes occur on the same clock edge.
- SIDE_G dwell is bounded to GREEN_MIN..GREEN_MAX cycles. Yellow is always followed by all-red before any conflicting green.

## Configuration
- `PED_WALK_EN` defined:
  - WALK state, `ped_pend` latch and `WALK_T` parameter are implemented.
  - `ped_req` is honored as above.
- `PED_WALK_EN` undefined:
  - WALK logic and `ped_pend` are removed.
  - `ped_req` is ignored, `walk` is tied to 0 and phase 6 is unreachable.
  - MAIN_G exits only on `side_req`. AR_1 always goes to SIDE_G.

## Test plan
- Reset, idle: release reset with no inputs. Expect phase 5 for 2 cycles, then phase 0 held for 100 cycles, light_1=001, light_2=100.
- Side-road pulse: 1-cycle `sensor_2` in MAIN_G cycle 3. Expect the sequence:
  - MAIN_G for 8 cycles total, then MAIN_Y 3, AR_1 2.
  - SIDE_G 8, SIDE_Y 3, AR_2 2.
  - Return to MAIN_G.
- Side-road hold: `sensor_2` tied to 1. Expect SIDE_G for exactly 20 cycles, then SIDE_Y; `side_req` re-latches in AR_2, so MAIN_G lasts exactly 8 cycles and the cycle repeats.
- Pedestrian (`PED_WALK_EN`):
  - `ped_req` pulse alone: expect MAIN_Y, AR_1, WALK for 6 cycles with walk=1 and 100/100, then AR_2, then MAIN_G.
  - `ped_req` together with `sensor_2`: expect WALK → SIDE_G.
- Reset mid-operation: drop `reset` in SIDE_G cycle 4, without a clock edge. Expect outputs 100/100, walk=0, phase=5 immediately; after release, prior requests are gone and MAIN_G holds.
- Macro off: repeated `ped_req` pulses with `sensor_2`=0 produce no state change from MAIN_G, and walk stays 0.
